// File: rtl/serial_link_obi_arbiter.sv
// Round-robin OBI arbiter in front of the serial-link wrapper; a FIFO of granted
// requester indices steers in-order responses back to their issuers.
module serial_link_obi_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumReq-1:0]                     req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  output logic [NumReq-1:0]                     gnt_o,
  output logic [NumReq-1:0]                     rvalid_o,
  output logic [NumReq-1:0][DataWidth-1:0]      rdata_o,
  output logic                                  req_o,
  output logic [AddrWidth-1:0]                  addr_o,
  output logic                                  we_o,
  output logic [DataWidth/8-1:0]                be_o,
  output logic [DataWidth-1:0]                  wdata_o,
  input  logic                                  gnt_i,
  input  logic                                  rvalid_i,
  input  logic [DataWidth-1:0]                  rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, winner, cand;
  logic            lock_q, lock_d, found, full, empty, grant, pop;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // A held lock overrides the round-robin search so a stalled request stays stable.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    if (lock_q) begin
      winner = lock_idx_q;
      found  = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        cand = IdxW'((32'(rr_q) + i) % NumReq);
        if (!found && req_i[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign req_o = rst_ni & found & req_i[winner] & ~full;
  assign grant = req_o & gnt_i;
  assign pop   = rst_ni & rvalid_i & ~empty;

  assign addr_o  = req_o ? addr_i[winner]  : '0;
  assign we_o    = req_o ? we_i[winner]    : 1'b0;
  assign be_o    = req_o ? be_i[winner]    : '0;
  assign wdata_o = req_o ? wdata_i[winner] : '0;

  assign outstanding_o = rst_ni ? cnt_q : '0;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (grant) gnt_o[winner] = 1'b1;
    if (pop)   rvalid_o[fifo_q[rd_q]] = 1'b1;
    for (int unsigned i = 0; i < NumReq; i++) rdata_o[i] = rdata_i;
  end

  always_comb begin
    lock_d     = req_o & ~gnt_i;
    lock_idx_d = req_o ? winner : lock_idx_q;
    rr_d       = rr_q;
    if (grant) rr_d = (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      err_o      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      if (grant) wr_q <= ptr_inc(wr_q);
      if (pop)   rd_q <= ptr_inc(rd_q);
      if (grant && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !grant) cnt_q <= cnt_q - 1'b1;
      if (rvalid_i && empty) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) fifo_q[wr_q] <= winner;
  end

endmodule

// File: tb/tb_serial_link_obi_arbiter.sv
// Directed bench for serial_link_obi_arbiter: round-robin, lock, full, push/pop at
// count 3, spurious response and mid-operation reset, NumReq=2, MaxOutstanding=4.
module tb_serial_link_obi_arbiter;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [1:0]        req_i;
  logic [1:0][31:0]  addr_i;
  logic [1:0]        we_i;
  logic [1:0][3:0]   be_i;
  logic [1:0][31:0]  wdata_i;
  logic [1:0]        gnt_o, rvalid_o;
  logic [1:0][31:0]  rdata_o;
  logic              req_o, we_o, gnt_i, rvalid_i, err_o;
  logic [31:0]       addr_o, wdata_o, rdata_i;
  logic [3:0]        be_o;
  logic [2:0]        outstanding_o;

  int n_tests = 0;
  int n_fail  = 0;

  serial_link_obi_arbiter #(
    .NumReq(2), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units later.
  task automatic cyc(input logic [1:0] r, input logic g, input logic rv, input logic [31:0] rd);
    req_i = r; gnt_i = g; rvalid_i = rv; rdata_i = rd;
    #4;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    addr_i  = '{32'h0000_2000, 32'h0000_1000};
    wdata_i = '{32'h0000_00B0, 32'h0000_00A0};
    we_i    = 2'b01;
    be_i    = '{4'h3, 4'hF};
    rst_ni  = 1'b0;
    req_i = 2'b11; gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    // in reset
    check_eq("rst_req_o", req_o, 0);
    check_eq("rst_gnt_o", gnt_o, 0);
    check_eq("rst_rvalid_o", rvalid_o, 0);
    check_eq("rst_outstanding", outstanding_o, 0);
    check_eq("rst_err", err_o, 0);
    rvalid_i = 1'b0;
    rst_ni = 1'b1;

    // round-robin
    cyc(2'b11, 1, 0, 0);
    check_eq("rr0_gnt", gnt_o, 2'b01);
    check_eq("rr0_addr", addr_o, 32'h1000);
    check_eq("rr0_wdata", wdata_o, 32'hA0);
    check_eq("rr0_be", be_o, 4'hF);
    check_eq("rr0_we", we_o, 1);
    tick();
    cyc(2'b11, 1, 1, 32'hD0);
    check_eq("rr1_gnt", gnt_o, 2'b10);
    check_eq("rr1_addr", addr_o, 32'h2000);
    check_eq("rr1_wdata", wdata_o, 32'hB0);
    check_eq("rr1_be", be_o, 4'h3);
    check_eq("rr1_we", we_o, 0);
    check_eq("rr1_rvalid", rvalid_o, 2'b01);
    check_eq("rr1_rdata0", rdata_o[0], 32'hD0);
    check_eq("rr1_rdata1", rdata_o[1], 32'hD0);
    tick();
    cyc(2'b11, 1, 1, 32'hD1);
    check_eq("rr2_gnt", gnt_o, 2'b01);
    check_eq("rr2_rvalid", rvalid_o, 2'b10);
    check_eq("rr2_rdata1", rdata_o[1], 32'hD1);
    tick();
    cyc(2'b11, 1, 1, 32'hD2);
    check_eq("rr3_gnt", gnt_o, 2'b10);
    check_eq("rr3_rvalid", rvalid_o, 2'b01);
    tick();
    cyc(2'b01, 1, 1, 32'hD3);
    check_eq("rr4_gnt", gnt_o, 2'b01);
    check_eq("rr4_rvalid", rvalid_o, 2'b10);
    tick();
    cyc(2'b00, 0, 1, 32'hD4);
    check_eq("rr5_rvalid", rvalid_o, 2'b01);
    tick();
    cyc(2'b00, 0, 0, 0);
    check_eq("rr_drained", outstanding_o, 0);

    // lock: rr_ptr is 1 here, so only the lock keeps master 0 selected
    cyc(2'b01, 0, 0, 0);
    check_eq("lk0_req", req_o, 1);
    check_eq("lk0_addr", addr_o, 32'h1000);
    check_eq("lk0_gnt", gnt_o, 0);
    tick();
    for (int c = 1; c <= 2; c++) begin
      cyc(2'b11, 0, 0, 0);
      check_eq("lk_hold_addr", addr_o, 32'h1000);
      tick();
    end
    cyc(2'b11, 1, 0, 0);
    check_eq("lk3_addr", addr_o, 32'h1000);
    check_eq("lk3_gnt", gnt_o, 2'b01);
    tick();
    cyc(2'b10, 1, 0, 0);
    check_eq("lk4_gnt", gnt_o, 2'b10);
    tick();
    cyc(2'b00, 0, 1, 0);
    check_eq("lk_rv0", rvalid_o, 2'b01);
    tick();
    cyc(2'b00, 0, 1, 0);
    check_eq("lk_rv1", rvalid_o, 2'b10);
    tick();

    // full: four grants to master 0, rr_ptr 0 beforehand
    for (int c = 0; c < 4; c++) begin
      cyc(2'b01, 1, 0, 0);
      check_eq("fill_gnt", gnt_o, 2'b01);
      tick();
    end
    cyc(2'b11, 1, 0, 0);
    check_eq("full_cnt", outstanding_o, 4);
    check_eq("full_req", req_o, 0);
    check_eq("full_gnt", gnt_o, 0);
    check_eq("full_addr", addr_o, 0);
    tick();
    cyc(2'b11, 1, 1, 32'hD5);
    check_eq("full_pop_req", req_o, 0);
    check_eq("full_pop_rv", rvalid_o, 2'b01);
    tick();
    // count 3: push (master 1) and pop in the same cycle
    cyc(2'b11, 1, 1, 32'hD6);
    check_eq("pp_cnt_before", outstanding_o, 3);
    check_eq("pp_req", req_o, 1);
    check_eq("pp_gnt", gnt_o, 2'b10);
    check_eq("pp_rv", rvalid_o, 2'b01);
    tick();
    cyc(2'b00, 0, 1, 0);
    check_eq("pp_cnt_after", outstanding_o, 3);
    check_eq("drain_rv0", rvalid_o, 2'b01);
    tick();
    cyc(2'b00, 0, 1, 0);
    check_eq("drain_rv1", rvalid_o, 2'b01);
    tick();
    cyc(2'b00, 0, 1, 0);
    check_eq("drain_rv2", rvalid_o, 2'b10);
    tick();
    cyc(2'b00, 0, 0, 0);
    check_eq("drain_cnt", outstanding_o, 0);

    // spurious response
    cyc(2'b00, 0, 1, 0);
    check_eq("sp_rv", rvalid_o, 0);
    check_eq("sp_err_now", err_o, 0);
    tick();
    for (int c = 0; c < 10; c++) begin
      cyc(2'b00, 0, 0, 0);
      check_eq("sp_err_sticky", err_o, 1);
      tick();
    end
    rst_ni = 1'b0;
    cyc(2'b00, 0, 0, 0);
    tick();
    rst_ni = 1'b1;
    cyc(2'b00, 0, 0, 0);
    check_eq("sp_err_clr", err_o, 0);

    // reset mid-operation with rr_ptr at 1 and two outstanding
    cyc(2'b01, 1, 0, 0);
    tick();
    cyc(2'b01, 1, 0, 0);
    tick();
    cyc(2'b00, 0, 0, 0);
    check_eq("mid_cnt", outstanding_o, 2);
    rst_ni = 1'b0;
    cyc(2'b11, 1, 0, 0);
    check_eq("mid_rst_req", req_o, 0);
    check_eq("mid_rst_gnt", gnt_o, 0);
    check_eq("mid_rst_cnt", outstanding_o, 0);
    tick();
    rst_ni = 1'b1;
    cyc(2'b11, 0, 0, 0);
    check_eq("post_cnt", outstanding_o, 0);
    check_eq("post_req", req_o, 1);
    check_eq("post_rr_addr", addr_o, 32'h1000);
    tick();
    cyc(2'b00, 0, 1, 0);
    check_eq("post_rv", rvalid_o, 0);
    tick();
    cyc(2'b00, 0, 0, 0);
    check_eq("post_err", err_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
